// File: rtl/opcode_byte_assembler.sv
// opcode_byte_assembler: packs 8-byte host link frames into
// Opcode_st words held behind a valid/ready output register.

package Opcode_p;

    typedef struct packed {
        logic [7:0]  flags;
        logic [11:0] arg4;
        logic [11:0] arg3;
        logic [11:0] arg2;
        logic [11:0] arg1;
        logic [7:0]  op;
    } Opcode_st;

endpackage

module opcode_byte_assembler
    import Opcode_p::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_OP         = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output Opcode_st   opcode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_bad_op,
    output logic       err_timeout
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [7:0]    MAX_OP_B = 8'(MAX_OP);
    localparam logic [2:0]    LAST     = 3'd7;

    logic [2:0]    cnt_q, cnt_d;
    logic [55:0]   hold_q, hold_d;
    Opcode_st      opcode_q, opcode_d;
    logic          out_valid_q, out_valid_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_bad_op_q, err_bad_op_d;
    logic          err_timeout_q, err_timeout_d;

    logic          accept;
    logic [TW-1:0] timer_inc;

    // The last byte may only land when the output slot is free or freeing.
    assign in_ready = (cnt_q != LAST) || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign timer_inc = timer_q + TMO_ONE;

    assign opcode      = opcode_q;
    assign out_valid   = out_valid_q;
    assign err_bad_op  = err_bad_op_q;
    assign err_timeout = err_timeout_q;

    // Frame assembly, op check, output handshake and idle timeout.
    always_comb begin
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        opcode_d      = opcode_q;
        out_valid_d   = out_valid_q;
        timer_d       = timer_q;
        err_bad_op_d  = 1'b0;
        err_timeout_d = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            timer_d = '0;
            if (cnt_q != LAST) begin
                hold_d[{cnt_q, 3'b000} +: 8] = in_data;
                cnt_d = cnt_q + 3'd1;
            end else begin
                cnt_d = '0;
                if (hold_q[7:0] <= MAX_OP_B) begin
                    opcode_d    = Opcode_st'({in_data, hold_q});
                    out_valid_d = 1'b1;
                end else begin
                    err_bad_op_d = 1'b1;
                end
            end
        end else if (cnt_q == 3'd0) begin
            timer_d = '0;
        end else if (in_ready) begin
            if (timer_inc == TMO_LIM) begin
                cnt_d         = '0;
                timer_d       = '0;
                err_timeout_d = 1'b1;
            end else begin
                timer_d = timer_inc;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            hold_q        <= '0;
            opcode_q      <= '0;
            out_valid_q   <= 1'b0;
            timer_q       <= '0;
            err_bad_op_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            opcode_q      <= opcode_d;
            out_valid_q   <= out_valid_d;
            timer_q       <= timer_d;
            err_bad_op_q  <= err_bad_op_d;
            err_timeout_q <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_opcode_byte_assembler.sv
// tb_opcode_byte_assembler: directed and random frames against a
// queue-based frame model of the opcode byte assembler.

module tb_opcode_byte_assembler;
    import Opcode_p::*;

    localparam int TMO = 10;
    localparam int MAXOP = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    Opcode_st   opcode;
    logic       out_valid;
    logic       out_ready;
    logic       err_bad_op;
    logic       err_timeout;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  mq[$];
    logic        m_ov;
    logic [63:0] m_op;
    int          m_idle;
    logic        m_bad;
    logic        m_tmo;
    logic        m_acc;
    int          n_bad_seen;
    int          n_tmo_seen;

    opcode_byte_assembler #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_OP(MAXOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .opcode(opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_bad_op(err_bad_op),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // One clock: drive, check in_ready, step the model, check outputs.
    task automatic cycle(input logic rst, input logic iv,
                         input logic [7:0] d, input logic ordy);
        logic        rdy;
        logic [63:0] w;
        reset     = rst;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        rdy = (mq.size() != 7) || !m_ov || ordy;
        if (!rst) chk("in_ready", in_ready, rdy);
        m_acc = 1'b0;
        m_bad = 1'b0;
        m_tmo = 1'b0;
        if (rst) begin
            mq.delete();
            m_ov   = 1'b0;
            m_op   = '0;
            m_idle = 0;
        end else begin
            if (m_ov && ordy) m_ov = 1'b0;
            if (iv && rdy) begin
                m_acc  = 1'b1;
                m_idle = 0;
                mq.push_back(d);
                if (mq.size() == 8) begin
                    w = '0;
                    foreach (mq[k]) w = w | (64'(mq[k]) << (8 * k));
                    if (int'(w[7:0]) <= MAXOP) begin
                        m_op = w;
                        m_ov = 1'b1;
                    end else begin
                        m_bad = 1'b1;
                    end
                    mq.delete();
                end
            end else if (mq.size() == 0) begin
                m_idle = 0;
            end else if (rdy) begin
                m_idle++;
                if (m_idle == TMO) begin
                    mq.delete();
                    m_idle = 0;
                    m_tmo  = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("opcode", opcode, m_op);
        chk("err_bad_op", err_bad_op, m_bad);
        chk("err_timeout", err_timeout, m_tmo);
        if (err_bad_op) n_bad_seen++;
        if (err_timeout) n_tmo_seen++;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ordy);
        for (int t = 0; t < 20; t++) begin
            cycle(1'b0, 1'b1, d, ordy);
            if (m_acc) return;
        end
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input logic [63:0] w, input logic ordy);
        for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8], ordy);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, ordy);
    endtask

    localparam logic [63:0] F_BASIC = 64'h5AAB_C789_4561_2301;
    localparam logic [63:0] F1      = 64'h1122_3344_5566_7701;
    localparam logic [63:0] F2      = 64'h8877_6655_4433_2203;
    localparam logic [63:0] F_BAD   = 64'h0000_0000_0000_0007;
    localparam logic [63:0] F_G00   = 64'hC3D4_E5F6_0718_2900;
    localparam logic [63:0] F_G02   = 64'h0102_0304_0506_0702;

    initial begin
        int          first_at;
        logic [63:0] fw;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_ov = 1'b0; m_op = '0; m_idle = 0;
        n_bad_seen = 0; n_tmo_seen = 0;

        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_ov", out_valid, 0);
        chk("rst_op", opcode, 0);
        chk("rst_rdy", in_ready, 1);

        // basic frame
        send_frame(F_BASIC, 1'b1);
        chk("b_ov", out_valid, 1);
        chk("b_opf", opcode.op, 8'h01);
        chk("b_a1", opcode.arg1, 12'h123);
        chk("b_a2", opcode.arg2, 12'h456);
        chk("b_a3", opcode.arg3, 12'h789);
        chk("b_a4", opcode.arg4, 12'hABC);
        chk("b_fl", opcode.flags, 8'h5A);
        idle(1, 1'b1);
        chk("b_pulse", out_valid, 0);

        // back-pressure
        send_frame(F1, 1'b0);
        for (int k = 0; k < 7; k++) send_byte(F2[8*k +: 8], 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, F2[63:56], 1'b0);
        chk("bp_rdy0", in_ready, 0);
        chk("bp_hold", opcode, F1);
        cycle(1'b0, 1'b1, F2[63:56], 1'b1);
        chk("bp_ov", out_valid, 1);
        chk("bp_op2", opcode, F2);
        idle(1, 1'b0);
        chk("bp_keep", opcode, F2);
        idle(1, 1'b1);
        chk("bp_done", out_valid, 0);

        // bad op
        n_bad_seen = 0;
        send_frame(F_BAD, 1'b1);
        idle(2, 1'b1);
        chk("bad_cnt", n_bad_seen, 1);
        chk("bad_ov", out_valid, 0);
        send_frame(F_G00, 1'b1);
        chk("g00", opcode, F_G00);
        idle(1, 1'b1);

        // timeout
        for (int k = 0; k < 3; k++) send_byte(8'h02, 1'b1);
        n_tmo_seen = 0;
        first_at = -1;
        for (int i = 1; i <= 15; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            if (err_timeout && first_at < 0) first_at = i;
        end
        chk("tmo_cnt", n_tmo_seen, 1);
        chk("tmo_at", first_at, 10);
        send_frame(F_G02, 1'b1);
        chk("g02_op", opcode.op, 8'h02);
        chk("g02", opcode, F_G02);
        idle(1, 1'b1);

        // timer freeze under back-pressure
        send_frame(F1, 1'b0);
        for (int k = 0; k < 7; k++) send_byte(F2[8*k +: 8], 1'b0);
        n_tmo_seen = 0;
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, F2[63:56], 1'b0);
        chk("frz_tmo", n_tmo_seen, 0);
        chk("frz_hold", opcode, F1);
        cycle(1'b0, 1'b1, F2[63:56], 1'b1);
        chk("frz_op2", opcode, F2);
        chk("frz_ov", out_valid, 1);
        idle(1, 1'b1);

        // reset mid-frame with an opcode held
        send_frame(F_G00, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(F_G02[8*k +: 8], 1'b0);
        n_bad_seen = 0; n_tmo_seen = 0;
        cycle(1'b1, 1'b1, 8'h55, 1'b0);
        chk("mr_ov", out_valid, 0);
        chk("mr_op", opcode, 0);
        chk("mr_rdy", in_ready, 1);
        chk("mr_err", n_bad_seen + n_tmo_seen, 0);
        send_frame(F1, 1'b1);
        chk("mr_f1", opcode, F1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic       iv;
            logic [7:0] d;
            iv = ($urandom_range(0, 99) < 70) && ((i % 300) > 14);
            d  = 8'($urandom);
            if (mq.size() == 0) d = 8'($urandom_range(0, 5));
            cycle(1'b0, iv, d, $urandom_range(0, 99) < 60);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/opcode_byte_assembler.md
# opcode_byte_assembler

Packs a byte stream from the host link (UART receive path) into complete `Opcode_p::Opcode_st` words for the motion-command stage directly downstream. Each opcode is an 8-byte frame. The block validates the op field, discards malformed or stalled frames with error pulses, and holds one finished opcode in an output register under a valid/ready handshake.

## Interface
- `TIMEOUT_CYCLES`, default 1000: consecutive idle cycles inside a partial frame before that frame is dropped; legal range ≥ 1.
- `MAX_OP`, default 3: highest legal op value (`OP_G03`).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  byte from the link.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `opcode`  out  64 (`Opcode_st`)  assembled opcode.
- `out_valid`  out  1  `opcode` holds an unconsumed opcode.
- `out_ready`  in  1  downstream consumes `opcode` this cycle.
- `err_bad_op`  out  1  one-cycle pulse: completed frame dropped for an illegal op.
- `err_timeout`  out  1  one-cycle pulse: partial frame dropped for inactivity.

## Operation
- **Byte accept:** `in_valid && in_ready`.
- **Frame word W[63:0]:** the first byte is W[7:0] and byte k is W[8k+7:8k].
- **Field map:**
  - op = W[7:0]
  - arg1 = W[19:8]
  - arg2 = W[31:20]
  - arg3 = W[43:32]
  - arg4 = W[55:44]
  - flags = W[63:56]
- **State:**
  - byte counter `cnt` (0..7)
  - 56-bit holding register for bytes 0..6
  - output register + `out_valid`
  - idle timer (width `$clog2(TIMEOUT_CYCLES+1)`)
- **Byte accepted with `cnt` < 7:** store the byte in slot `cnt`; `cnt` increments; timer clears.
- **Byte accepted with `cnt` = 7 (frame complete):**
  - If op ≤ `MAX_OP`: load the output register with {byte, holding}; `out_valid` ← 1.
  - Otherwise: discard the frame; `err_bad_op` ← 1 for one cycle; output register and `out_valid` unchanged.
  - In both cases `cnt` ← 0 and the timer clears.
- **`in_ready`** = (`cnt` ≠ 7) || !`out_valid` || `out_ready`.
  - Bytes 0..6 are always accepted.
  - The final byte is accepted only if the output slot is free or being freed this cycle.
- **Output handshake:**
  - `out_valid && out_ready` consumes the opcode; `out_valid` ← 0 unless a new valid frame completes in the same cycle, in which case the new opcode loads and `out_valid` stays 1.
  - While `out_valid` = 1 and `out_ready` = 0, `opcode` is held stable.
- **Timeout:**
  - The timer increments only when `cnt` ≠ 0, `in_ready` = 1 and `in_valid` = 0.
  - It clears on any accepted byte and whenever `cnt` = 0.
  - Back-pressure (`in_ready` = 0) freezes the timer without clearing it.
  - When the timer reaches `TIMEOUT_CYCLES`: `cnt` ← 0, timer ← 0, `err_timeout` ← 1 for one cycle. The output register is unaffected.
- **Byte arriving in the same cycle the timer hits `TIMEOUT_CYCLES`:** cannot occur, because counting requires `in_valid` = 0. An accepted byte always wins.
- **Reset values (all outputs):**
  - `cnt`, timer = 0
  - `out_valid` = 0
  - `opcode` = all zeros
  - `err_bad_op`, `err_timeout` = 0
  - `in_ready` = 1 (derived from `cnt` = 0)
- **Reset mid-frame:** discards the partial frame and any held opcode; no error pulse.

## Timing
- **Latency:** final byte accepted at edge N → `out_valid` = 1 and `opcode` valid after edge N, i.e. visible in cycle N+1.
- **`err_bad_op`:** asserted in cycle N+1 for exactly one cycle.
- **`err_timeout`:** asserted in the cycle after the timer reaches `TIMEOUT_CYCLES`.
- **Throughput:** one byte per cycle sustained, so one opcode per 8 cycles with `out_ready` held high; there are no bubbles at frame boundaries.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready`. No other input→output combinational path exists.

## Test plan
- **Basic frame:** reset, then stream 01 23 61 45 89 C7 AB 5A back-to-back with `out_ready` = 1.
  - `out_valid` pulses one cycle after the last byte.
  - `opcode` = {op 0x01, arg1 0x123, arg2 0x456, arg3 0x789, arg4 0xABC, flags 0x5A}.
- **Back-pressure:** hold `out_ready` = 0 and send two full frames.
  - The first opcode is held stable.
  - `in_ready` drops when `cnt` = 7; the 16th byte stalls.
  - Raise `out_ready` for one cycle: the 16th byte is accepted in that same cycle and the second opcode appears the next cycle with `out_valid` still 1.
- **Bad op:** send frame 07 00 00 00 00 00 00 00.
  - `err_bad_op` pulses once.
  - `out_valid` stays 0.
  - A following valid G00 frame assembles correctly.
- **Timeout:** with `TIMEOUT_CYCLES` = 10, send 3 bytes, then idle.
  - `err_timeout` pulses exactly once, 10 idle cycles later.
  - Then send a full G02 frame: it decodes with op = 2, with no byte misalignment.
- **Timer freeze:** hold `out_ready` = 0 with `out_valid` = 1 and `cnt` = 7 for 50 cycles (`TIMEOUT_CYCLES` = 10).
  - No `err_timeout`.
  - The frame completes once `out_ready` rises.
- **Reset mid-frame:** assert `reset` after 4 bytes.
  - All outputs return to reset values next cycle, with no error pulse.
  - The following 8-byte frame decodes from byte 0.
